// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and counter-width helper for alu_seq.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bits needed to count WIDTH-1 down to 0 (also the shift-amount width).
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add, LSB first) / restoring divide (MSB first).
// Latency: WIDTH cycles after start; done flags the cycle whose combinational outputs are final.
// Backpressure: none; the parent only starts it when the result register can take the answer.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);

  // acc: product accumulator (mul) or partial remainder (div).
  // opa: multiplicand shifting left (mul) or dividend shifting out / quotient shifting in (div).
  // opb: multiplier shifting right (mul) or fixed divisor (div).
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic             div_q, run_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] mul_acc_d, div_acc_d, div_opa_d;
  logic [WIDTH:0]   rem_sh, trial;

  // One iteration step of each algorithm, computed from the current registers.
  always_comb begin
    mul_acc_d = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh    = {acc_q, opa_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, opb_q};
    if (!trial[WIDTH]) begin
      div_acc_d = trial[WIDTH-1:0];
      div_opa_d = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_d = rem_sh[WIDTH-1:0];
      div_opa_d = {opa_q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand load on start, then one step per cycle until the counter expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      opa_q <= a;
      opb_q <= b;
      div_q <= is_div;
      run_q <= 1'b1;
      cnt_q <= CNT_INIT;
    end else if (run_q) begin
      if (div_q) begin
        acc_q <= div_acc_d;
        opa_q <= div_opa_d;
      end else begin
        acc_q <= mul_acc_d;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign done    = run_q && (cnt_q == '0);
  assign prod_lo = mul_acc_d;
  assign quot    = div_opa_d;
  assign rem     = div_acc_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; mul/divu/remu iterative when ALU_SEQ_MULDIV_EN is defined.
// Latency: 1 cycle for single-cycle ops (and illegal/divide-by-zero), WIDTH cycles for mul/divu/remu.
// Backpressure: in_ready only while idle and the result register is empty or draining this cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int               SW    = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic                    out_free, accept;
  logic [WIDTH:0]          sum, diff;
  logic                    big_shift;
  logic [SW-1:0]           shamt;
  logic signed [WIDTH-1:0] sra_val;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_carry, sc_ovf, sc_err, sc_multi;
  logic                    load_sc, load_md;
  logic [WIDTH-1:0]        md_res;
  logic [WIDTH-1:0]        nxt_res;

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Single-cycle result and flags; sc_multi marks ops that must iterate instead.
  always_comb begin
    sc_res    = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    sc_multi  = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    big_shift = (b >= W_VAL);
    shamt     = b[SW-1:0];
    sra_val   = $signed(a) >>> shamt;
    case (op)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~a;
      OP_SHL:  sc_res = big_shift ? '0 : (a << shamt);
      OP_SHR:  sc_res = big_shift ? '0 : (a >> shamt);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_SRA:  sc_res = big_shift ? {WIDTH{a[WIDTH-1]}} : sra_val;
      OP_XOR:  sc_res = a ^ b;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL:  sc_multi = 1'b1;
      OP_DIVU: begin
        if (b == '0) begin
          sc_res = '1;
          sc_err = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_REMU: begin
        if (b == '0) begin
          sc_res = a;
          sc_err = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  assign load_sc = accept && !sc_multi;

`ifdef ALU_SEQ_MULDIV_EN
  state_t           state_q, state_d;
  logic [3:0]       md_op_q;
  logic             md_done;
  logic [WIDTH-1:0] md_prod, md_quot, md_rem;

  assign in_ready = rst_n && (state_q == IDLE) && out_free;
  assign load_md  = (state_q == BUSY) && md_done;
  assign md_res   = (md_op_q == OP_MUL)  ? md_prod :
                    (md_op_q == OP_DIVU) ? md_quot : md_rem;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Enter BUSY on an accepted iterative op; leave when the iterator finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && sc_multi) state_d = BUSY;
      BUSY:    if (md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remember which iterative output to pick up at completion.
  always_ff @(posedge clk) begin
    if (!rst_n)                   md_op_q <= '0;
    else if (accept && sc_multi)  md_op_q <= op;
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && sc_multi),
    .is_div  (op != OP_MUL),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .prod_lo (md_prod),
    .quot    (md_quot),
    .rem     (md_rem)
  );
`else
  assign in_ready = rst_n && out_free;
  assign load_md  = 1'b0;
  assign md_res   = '0;
`endif

  assign nxt_res = load_md ? md_res : sc_res;

  // Result/flag register: loads on completion, holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (load_sc || load_md) begin
      out_valid <= 1'b1;
      result    <= nxt_res;
      zero      <= (nxt_res == '0);
      neg       <= nxt_res[WIDTH-1];
      carry     <= load_md ? 1'b0 : sc_carry;
      ovf       <= load_md ? 1'b0 : sc_ovf;
      err       <= load_md ? 1'b0 : sc_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It accepts one operation per transaction over a valid/ready input and returns a registered result with flags over a valid/ready output. Single-cycle ops complete in one cycle. Optional iterative multiply/divide runs WIDTH cycles. It sits between the register-file read stage and writeback, and its handshake lets the pipeline stall around multi-cycle ops.

## Interface
- WIDTH, 16, operand/result width; must be at least 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  4  opcode (see Operation).
- a  in  WIDTH  source 1.
- b  in  WIDTH  source 2.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result equals 0.
- neg  out  1  result[WIDTH-1].
- carry  out  1  add: carry-out; sub: borrow (a<b unsigned); otherwise 0.
- ovf  out  1  signed overflow for add/sub; otherwise 0.
- err  out  1  illegal opcode, or divide by zero.

## Operation
- Opcodes:
  - 0 add; 1 sub; 2 not a; 3 shl; 4 shr (logical); 5 and; 6 or.
  - 7 sltu (1 if a<b unsigned, else 0); 8 sra; 9 xor.
  - 10 mul (low WIDTH bits of unsigned product); 11 divu (quotient); 12 remu (remainder).
  - 13–15 illegal: result 0, err=1.
- Shifts use the full unsigned value of b. If b ≥ WIDTH: shl/shr give 0; sra gives WIDTH copies of a[WIDTH-1].
- All arithmetic is modulo 2^WIDTH. Flags are computed from the final result and registered with it.
- A transfer occurs on any cycle where in_valid and in_ready are both high. Operands and op are captured at that edge; inputs are don't-care afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle drain-and-accept is allowed.
- FSM states:
  - IDLE → IDLE on a single-cycle op, or on a divide with b==0. The result register loads at the accept edge.
  - IDLE → BUSY on mul/divu/remu with b≠0 (mul: any b). The iteration counter loads WIDTH-1.
  - BUSY decrements the counter each cycle. At 0 it loads the result register and returns to IDLE.
- Multiply: shift-add, one bit of b per cycle, LSB first.
- Divide: restoring, one quotient bit per cycle, MSB first.
- Divide by zero: quotient all-ones, remainder = a, err=1, single-cycle completion.
- The result register holds, unchanged, while out_valid && !out_ready. A finishing BUSY op cannot collide with an undrained result, because in_ready gated entry.
- Reset values: out_valid=0, result=0, zero=0, neg=0, carry=0, ovf=0, err=0, state=IDLE, counter=0. in_ready is 0 during reset and 1 on the first cycle after it.
- Reset mid-BUSY: the op is abandoned and no result is produced.

## Timing
- Single-cycle ops: accept at edge N → out_valid high after edge N (latency 1).
- mul/divu/remu: accept at edge N → out_valid high after edge N+WIDTH (latency WIDTH). in_ready is low for cycles N+1..N+WIDTH.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.

## Configuration
- ALU_SEQ_MULDIV_EN:
  - Defined: opcodes 10–12 behave as above. The BUSY state, counter and iterator are present.
  - Undefined: opcodes 10–12 are treated as illegal (result 0, err=1, latency 1). No BUSY logic is synthesised, and in_ready depends only on the output register.

## Structure
- alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_REMU);
  - the state enum (IDLE, BUSY);
  - the width helper for the counter: $clog2(WIDTH).
- Sub-module alu_seq_muldiv: iterative multiply/divide datapath.
  - Inputs: start, is_div, a, b.
  - Outputs: done, prod_lo, quot, rem.
  - Instantiated only under ALU_SEQ_MULDIV_EN.

## Test plan
- Test 1, flags (WIDTH=16): add 0x7FFF+0x0001 → result 0x8000, ovf=1, neg=1, carry=0. Then sub 0x0003−0x0005 → 0xFFFE, carry=1.
- Test 2, shifts: shl a=0x0001, b=16 → 0x0000. sra a=0x8000, b=20 → 0xFFFF. shr a=0x8000, b=15 → 0x0001.
- Test 3, throughput and stall: 8 back-to-back adds with out_ready=1 → 8 results on consecutive cycles. With out_ready=0 after the first, in_ready drops and the result holds stable until out_ready rises.
- Test 4, MULDIV_EN: mul 0x00FF×0x0101 → 0xFFFF after 16 cycles, with in_ready low throughout. divu 100/7 → 14; remu → 2.
- Test 5, errors: divu a=0x1234, b=0 → 0xFFFF, err=1, latency 1. remu a=0x1234, b=0 → 0x1234, err=1. op=15 → 0, err=1, zero=1.
- Test 6, reset mid-BUSY: rst_n low at cycle 5 of a mul → out_valid stays 0, all outputs 0. A subsequent add 2+3 → 5 with latency 1.
